// File: rtl/input_router_vc_if.sv
// Flit channel between the input buffer, the route stage and the switch allocator.
// The slave modport is the router side; the master modport drives and observes it.
interface input_router_vc_if #(
  parameter int FLIT_W = 34,
  parameter int VC_W   = 1
);
  logic              flit_valid_i;
  logic [FLIT_W-1:0] flit_i;
  logic              flit_ready_o;
  logic              flit_valid_o;
  logic [FLIT_W-1:0] flit_o;
  logic [VC_W-1:0]   vc_id_o;
  logic [4:0]        router_port_o;
  logic              flit_ready_i;

  modport slave (
    input  flit_valid_i, flit_i, flit_ready_i,
    output flit_ready_o, flit_valid_o, flit_o, vc_id_o, router_port_o
  );

  modport master (
    output flit_valid_i, flit_i, flit_ready_i,
    input  flit_ready_o, flit_valid_o, flit_o, vc_id_o, router_port_o
  );
endinterface

// File: rtl/input_router_vc.sv
// NoC input-port route stage: XY route computed on head flits, held per VC until the tail,
// and presented through one registered valid/ready output stage.
module input_router_vc #(
  parameter int FLIT_W = 34,
  parameter int NUM_VC = 2,
  parameter int X_W    = 2,
  parameter int Y_W    = 2,
  parameter int ERR_W  = 8
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic [X_W-1:0]        router_x_i,
  input  logic [Y_W-1:0]        router_y_i,
  input_router_vc_if.slave      bus,
  output logic                  err_o,
  output logic [ERR_W-1:0]      err_cnt_o
);
  localparam int VC_W = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;

  localparam logic [4:0] PORT_N     = 5'b00001;
  localparam logic [4:0] PORT_S     = 5'b00010;
  localparam logic [4:0] PORT_W     = 5'b00100;
  localparam logic [4:0] PORT_E     = 5'b01000;
  localparam logic [4:0] PORT_LOCAL = 5'b10000;

  typedef enum logic [1:0] {
    HEAD      = 2'b00,
    BODY      = 2'b01,
    TAIL      = 2'b10,
    HEAD_TAIL = 2'b11
  } flit_type_e;

  // Valid/ready: a flit moves whenever valid and ready are both high at a clock edge.
  // The output register may load when it is empty or being drained this cycle, and
  // it holds its contents unchanged while flit_valid_o && !flit_ready_i.
  logic [NUM_VC-1:0] entry_valid;
  logic [4:0]        entry_route [NUM_VC];

  flit_type_e        flit_type;
  logic [X_W-1:0]    x_dest;
  logic [Y_W-1:0]    y_dest;
  logic [VC_W-1:0]   vc;
  logic              vc_ok;
  logic              is_head;
  logic              stored_valid;
  logic [4:0]        stored_route;
  logic [4:0]        route_calc;
  logic [4:0]        out_route;
  logic              accept;
  logic              fwd;
  logic              err;

  assign bus.flit_ready_o = !bus.flit_valid_o || bus.flit_ready_i;
  assign accept           = bus.flit_valid_i && bus.flit_ready_o;

  always_comb begin
    flit_type    = flit_type_e'(bus.flit_i[FLIT_W-1 -: 2]);
    x_dest       = bus.flit_i[FLIT_W-3 -: X_W];
    y_dest       = bus.flit_i[FLIT_W-3-X_W -: Y_W];
    vc           = bus.flit_i[VC_W-1:0];
    vc_ok        = (32'(vc) < 32'(NUM_VC));
    is_head      = (flit_type == HEAD) || (flit_type == HEAD_TAIL);
    stored_valid = 1'b0;
    stored_route = '0;
    if (vc_ok) begin
      stored_valid = entry_valid[vc];
      stored_route = entry_route[vc];
    end

    // X is resolved before Y, which keeps XY routing deadlock-free on a mesh.
    route_calc = PORT_LOCAL;
    if (x_dest > router_x_i)      route_calc = PORT_E;
    else if (x_dest < router_x_i) route_calc = PORT_W;
    else if (y_dest < router_y_i) route_calc = PORT_N;
    else if (y_dest > router_y_i) route_calc = PORT_S;

    out_route = is_head ? route_calc : stored_route;
    fwd       = vc_ok && (is_head || stored_valid);
    // A head on an open entry and a body/tail on a closed entry are both protocol errors.
    err       = !vc_ok || (is_head == stored_valid);
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      bus.flit_valid_o  <= 1'b0;
      bus.flit_o        <= '0;
      bus.vc_id_o       <= '0;
      bus.router_port_o <= '0;
      err_o             <= 1'b0;
      err_cnt_o         <= '0;
      entry_valid       <= '0;
    end else begin
      if (bus.flit_ready_o) begin
        bus.flit_valid_o  <= accept && fwd;
        bus.router_port_o <= '0;
        if (accept && fwd) begin
          bus.flit_o        <= bus.flit_i;
          bus.vc_id_o       <= vc;
          bus.router_port_o <= out_route;
        end
      end

      err_o <= accept && err;
      if (accept && err && (err_cnt_o != '1)) err_cnt_o <= err_cnt_o + ERR_W'(1);

      if (accept && vc_ok) begin
        unique case (flit_type)
          HEAD: begin
            entry_valid[vc] <= 1'b1;
            entry_route[vc] <= route_calc;
          end
          HEAD_TAIL, TAIL: entry_valid[vc] <= 1'b0;
          BODY:            ;
        endcase
      end
    end
  end
endmodule
